// File: rtl/turbo_switch_ctrl.sv
// -----------------------------------------------------------------------------
// turbo_switch_ctrl
//
// Sequences the CPU speed selection handed to the clock-enable generator.
// The CPU writes a requested speed (turbo_target). While speed-critical
// activity is flagged by force_slow, the CPU is held at 3.5 MHz. After
// force_slow drops, a hold-off of HOLDOFF_TICKS clk35en ticks must pass
// before turbo is restored. The applied speed (turbo_option) only ever
// changes on an uncontended clk35en edge. This means the CPU enable never
// shows a runt or doubled pulse.
//
// Ports
//   clk            master clock (28 MHz), shared with the enable generator
//   rst            synchronous active-high reset
//   clk35en        3.5 MHz phase pulse; the only point where turbo_option moves
//   CPUContention  ULA contention active; blocks turbo_option updates
//   turbo_wr       one-cycle strobe: CPU writes a new speed
//   turbo_req      requested speed (00 3.5, 01 7, 10 14, 11 28 MHz)
//   force_slow     level: hold the CPU at 3.5 MHz
//   turbo_option   applied speed, to the clock-enable generator
//   turbo_target   latched CPU-requested speed (read-back)
//   turbo_busy     high while the desired speed differs from turbo_option
//   slow_active    high while forced slow or in hold-off
// -----------------------------------------------------------------------------
module turbo_switch_ctrl #(
  parameter int HOLDOFF_TICKS = 3500,
  parameter int CNTW          = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk35en,
  input  logic       CPUContention,
  input  logic       turbo_wr,
  input  logic [1:0] turbo_req,
  input  logic       force_slow,
  output logic [1:0] turbo_option,
  output logic [1:0] turbo_target,
  output logic       turbo_busy,
  output logic       slow_active
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FORCED  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] HOLDOFF_LOAD = CNTW'(HOLDOFF_TICKS);
  localparam logic [CNTW-1:0] CNT_ONE      = CNTW'(1);

  state_t          state_reg, state_next;
  logic [CNTW-1:0] count_reg, count_next;
  logic [1:0]      turbo_option_reg;
  logic [1:0]      turbo_target_reg;
  logic            slow_active_reg;
  logic [1:0]      desired;
  logic            update_en;

  // Speed changes are only safe on a 3.5 MHz boundary that the ULA is not
  // currently stretching.
  assign update_en = clk35en & ~CPUContention;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_RUN;
      count_reg        <= '0;
      turbo_option_reg <= 2'b00;
      turbo_target_reg <= 2'b00;
      slow_active_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      slow_active_reg <= (state_next != ST_RUN);
      if (turbo_wr) begin
        turbo_target_reg <= turbo_req;
      end
      // desired comes from the pre-edge state and target. A write or a
      // force_slow on the same edge therefore takes effect at the next
      // update edge, not this one.
      if (update_en) begin
        turbo_option_reg <= desired;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      ST_RUN: begin
        if (force_slow) begin
          state_next = ST_FORCED;
        end
      end
      ST_FORCED: begin
        if (!force_slow) begin
          if (HOLDOFF_TICKS == 0) begin
            state_next = ST_RUN;
          end else begin
            state_next = ST_HOLDOFF;
            count_next = HOLDOFF_LOAD;
          end
        end
      end
      ST_HOLDOFF: begin
        // A re-assertion abandons the partial count. It is reloaded in full
        // when FORCED is left again. Ticks are counted regardless of
        // contention, because contention only delays the speed change, not
        // the hold-off time.
        if (force_slow) begin
          state_next = ST_FORCED;
        end else if (clk35en) begin
          if (count_reg == CNT_ONE) begin
            state_next = ST_RUN;
          end else begin
            count_next = count_reg - CNT_ONE;
          end
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    desired    = (state_reg == ST_RUN) ? turbo_target_reg : 2'b00;
    turbo_busy = (desired != turbo_option_reg);
  end

  assign turbo_option = turbo_option_reg;
  assign turbo_target = turbo_target_reg;
  assign slow_active  = slow_active_reg;

endmodule

// File: tb/tb_turbo_switch_ctrl.sv
// Randomised bench for turbo_switch_ctrl against a behavioural model.
// The model tracks the slow phase as a "forced" flag plus a number of
// remaining hold-off ticks. The CPU is running at the target speed only
// when neither of them is pending.
module tb_turbo_switch_ctrl;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk35en;
  logic       CPUContention;
  logic       turbo_wr;
  logic [1:0] turbo_req;
  logic       force_slow;
  logic [1:0] turbo_option;
  logic [1:0] turbo_target;
  logic       turbo_busy;
  logic       slow_active;

  turbo_switch_ctrl #(.HOLDOFF_TICKS(H), .CNTW(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk35en      (clk35en),
    .CPUContention(CPUContention),
    .turbo_wr     (turbo_wr),
    .turbo_req    (turbo_req),
    .force_slow   (force_slow),
    .turbo_option (turbo_option),
    .turbo_target (turbo_target),
    .turbo_busy   (turbo_busy),
    .slow_active  (slow_active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state (post-edge).
  int m_target, m_option, m_left;
  bit m_forced;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int model_desired();
    return (!m_forced && m_left == 0) ? m_target : 0;
  endfunction

  // Advance the model across one clock edge using the current inputs.
  task automatic model_step();
    int d;
    if (rst) begin
      m_target = 0; m_option = 0; m_left = 0; m_forced = 0;
      return;
    end
    d = model_desired();
    if (clk35en && !CPUContention) m_option = d;
    if (turbo_wr) m_target = int'(turbo_req);
    if (force_slow) begin
      m_forced = 1;
    end else if (m_forced) begin
      m_forced = 0;
      m_left   = H;
    end else if (m_left > 0 && clk35en) begin
      m_left--;
    end
  endtask

  task automatic check_all();
    check_eq("turbo_option", turbo_option, m_option);
    check_eq("turbo_target", turbo_target, m_target);
    check_eq("turbo_busy",   turbo_busy,   model_desired() != m_option);
    check_eq("slow_active",  slow_active,  m_forced || m_left != 0);
  endtask

  // Drive inputs for one cycle, advance the model, and check after the edge.
  task automatic cycle(input bit r, input bit en, input bit cont, input bit wr,
                       input logic [1:0] req, input bit fs);
    rst = r; clk35en = en; CPUContention = cont;
    turbo_wr = wr; turbo_req = req; force_slow = fs;
    model_step();
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  initial begin
    int phase;
    bit fs_lvl, cont_lvl;
    logic [1:0] req;
    bit wr, r;
    rst = 1'b1; clk35en = 1'b0; CPUContention = 1'b0;
    turbo_wr = 1'b0; turbo_req = 2'b00; force_slow = 1'b0;
    @(negedge clk);
    cycle(1, 0, 0, 0, 2'b00, 0);
    cycle(1, 1, 1, 1, 2'b11, 1);  // reset wins over everything

    // Directed: write 10 mid-phase, then hit a clk35en.
    cycle(0, 0, 0, 1, 2'b10, 0);
    check_eq("dir_busy_after_wr", turbo_busy, 1);
    cycle(0, 0, 0, 0, 2'b00, 0);
    cycle(0, 1, 0, 0, 2'b00, 0);
    check_eq("dir_option_14", turbo_option, 2'b10);

    // Directed: force slow with a simultaneous write of 01.
    cycle(0, 0, 0, 1, 2'b01, 1);
    for (int i = 0; i < 8; i++) cycle(0, i == 7, 0, 0, 2'b00, 1);
    check_eq("dir_forced_00", turbo_option, 2'b00);
    check_eq("dir_target_01", turbo_target, 2'b01);
    for (int i = 0; i < 48; i++) cycle(0, (i % 8) == 7, 0, 0, 2'b00, 0);
    check_eq("dir_restored_01", turbo_option, 2'b01);

    // Random phase.
    phase = 0; fs_lvl = 0; cont_lvl = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 39) == 0) fs_lvl = ~fs_lvl;
      if ($urandom_range(0, 15) == 0) cont_lvl = ~cont_lvl;
      wr  = ($urandom_range(0, 19) == 0);
      req = 2'($urandom_range(0, 3));
      r   = ($urandom_range(0, 799) == 0);
      cycle(r, phase == 7, cont_lvl, wr, req, fs_lvl);
      phase = (phase + 1) % 8;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
